avmm_tcm_slave: RTL and testbench

Avalon-MM pipelined slave: a tightly coupled scratch memory that answers the core's instruction or LSU master port (read/write/busy/rvalid/wrespvalid) with fixed, in-order latency. It sits on the far side of the core wrapper's Avalon-MM masters. It gives the core a zero-wait-state local RAM, returns a response for every write, and signals decode errors for out-of-range addresses. It clears itself after every reset before accepting traffic.

---
 rtl/avmm_pkg.sv | 22 ++
 rtl/avmm_tcm_slave_if.sv | 26 ++
 rtl/avmm_resp_pipe.sv | 26 ++
 rtl/avmm_tcm_slave.sv | 110 +++++++++++
 tb/tb_avmm_tcm_slave.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/avmm_pkg.sv
// Shared types for the Avalon-MM tightly coupled scratch memory slave.
package avmm_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } tcm_state_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    resp_t       resp;
    logic [31:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/avmm_tcm_slave_if.sv
// Avalon-MM pipelined bus between a core master port and the TCM slave.
interface avmm_tcm_slave_if;
  import avmm_pkg::*;

  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        busy;
  logic        rvalid;
  logic [31:0] rdata;
  resp_t       resp;
  logic        wrespvalid;

  modport master (
    output read, write, addr, be, wdata,
    input  busy, rvalid, rdata, resp, wrespvalid
  );

  modport slave (
    input  read, write, addr, be, wdata,
    output busy, rvalid, rdata, resp, wrespvalid
  );

endinterface

// File: rtl/avmm_resp_pipe.sv
// Fixed-depth in-order response delay line; reset discards everything in flight.
module avmm_resp_pipe
  import avmm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  rsp_entry_t push,
  output rsp_entry_t tail
);

  rsp_entry_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[DEPTH-1];

endmodule

// File: rtl/avmm_tcm_slave.sv
// Tightly coupled scratch RAM on an Avalon-MM pipelined slave port.
// Self-clears after reset, then answers every request with fixed latency.
module avmm_tcm_slave
  import avmm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic              clk,
  input logic              rst_n,
  avmm_tcm_slave_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * MEM_WORDS);

  logic [31:0]      mem [MEM_WORDS];
  tcm_state_t       state;
  logic [IDX_W-1:0] clr_cnt;
  logic             busy_q;

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             accept;
  rsp_entry_t       push;
  rsp_entry_t       tail;

  // Offset compare avoids overflow when BASE_ADDR+SPAN wraps past 2^32.
  always_comb begin
    offset   = bus.addr - BASE_ADDR;
    in_range = (bus.addr >= BASE_ADDR) && (offset < SPAN);
    idx      = offset[IDX_W+1:2];
    accept   = (bus.read || bus.write) && !busy_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IDX_W'(MEM_WORDS - 1)) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        RUN: busy_q <= 1'b0;
        default: begin
          state  <= INIT;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Memory has no reset of its own; the INIT sweep zeroes it word by word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[clr_cnt] <= '0;
      end else if (accept && bus.write && in_range) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (bus.be[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // A read alongside a write is dropped: the entry is tagged as a write.
  always_comb begin
    push = '0;
    if (accept) begin
      push.valid    = 1'b1;
      push.is_write = bus.write;
      push.resp     = in_range ? OKAY : DECERR;
      if (!bus.write && in_range) push.data = mem[idx];
    end
  end

  avmm_resp_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_resp_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .tail (tail)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rvalid     <= 1'b0;
      bus.wrespvalid <= 1'b0;
      bus.rdata      <= '0;
      bus.resp       <= OKAY;
    end else begin
      bus.rvalid     <= tail.valid && !tail.is_write;
      bus.wrespvalid <= tail.valid && tail.is_write;
      bus.rdata      <= (tail.valid && !tail.is_write) ? tail.data : '0;
      bus.resp       <= tail.valid ? tail.resp : OKAY;
    end
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_avmm_tcm_slave.sv
// Bench for avmm_tcm_slave: behavioural memory/response model plus directed sequences.
module tb_avmm_tcm_slave;
  import avmm_pkg::*;

  localparam int          MW   = 16;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avmm_tcm_slave_if bus ();

  avmm_tcm_slave #(
    .BASE_ADDR   (BASE),
    .MEM_WORDS   (MW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Model: memory as a plain array, responses as a time-stamped queue.
  typedef struct {
    int          due;
    bit          isw;
    logic [1:0]  resp;
    logic [31:0] data;
  } pend_t;

  logic [31:0] mmem [MW];
  pend_t       pq [$];
  pend_t       p;
  int          n_run = 0;
  bit          m_busy, m_in;
  longint      la;
  int          word;
  logic        exp_busy = 1'b1, exp_rv = 1'b0, exp_wv = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_resp = 2'b00;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      n_run = 0;
      pq.delete();
      for (int i = 0; i < MW; i++) mmem[i] = '0;
      exp_busy = 1'b1; exp_rv = 1'b0; exp_wv = 1'b0; exp_rdata = '0; exp_resp = 2'b00;
    end else begin
      m_busy = (n_run < MW);
      if (!m_busy && (bus.read || bus.write)) begin
        la   = longint'(bus.addr);
        m_in = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * MW);
        word = m_in ? int'((la - longint'(BASE)) / 4) : 0;
        if (bus.write) begin
          if (m_in)
            for (int b = 0; b < 4; b++)
              if (bus.be[b]) mmem[word][8*b +: 8] = bus.wdata[8*b +: 8];
          pq.push_back('{cyc + LAT, 1'b1, m_in ? 2'b00 : 2'b11, 32'h0});
        end else begin
          pq.push_back('{cyc + LAT, 1'b0, m_in ? 2'b00 : 2'b11, m_in ? mmem[word] : 32'h0});
        end
      end
      if (n_run < MW) n_run++;
      exp_busy = (n_run < MW);
      exp_rv = 1'b0; exp_wv = 1'b0; exp_rdata = '0; exp_resp = 2'b00;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        exp_rv    = !p.isw;
        exp_wv    = p.isw;
        exp_rdata = p.data;
        exp_resp  = p.resp;
      end
    end
  end

  typedef struct {
    int          cyc;
    bit          isw;
    logic [1:0]  resp;
    logic [31:0] data;
  } obs_t;
  obs_t obs [$];

  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
    chk("wrespvalid", 32'(bus.wrespvalid), 32'(exp_wv));
    chk("rdata", bus.rdata, exp_rdata);
    chk("resp", 32'(bus.resp), 32'(exp_resp));
    if (bus.rvalid || bus.wrespvalid)
      obs.push_back('{cyc, bus.wrespvalid, bus.resp, bus.rdata});
  end

  task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output int acc);
    @(negedge clk);
    bus.read = r; bus.write = w; bus.addr = a; bus.be = b; bus.wdata = d;
    acc = cyc + 1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic chk_obs(input string nm, input int i, input int ecyc, input bit isw,
                         input logic [1:0] r, input logic [31:0] d);
    if (i >= obs.size()) begin
      total++;
      bad++;
      $display("FAIL %s actual=missing required=response at edge %0d", nm, ecyc);
    end else begin
      chk({nm, "_edge"}, 32'(obs[i].cyc), 32'(ecyc));
      chk({nm, "_kind"}, 32'(obs[i].isw), 32'(isw));
      chk({nm, "_resp"}, 32'(obs[i].resp), 32'(r));
      chk({nm, "_data"}, obs[i].data, d);
    end
  endtask

  task automatic wait_ready(input string nm, output int low_edge);
    bit done;
    done = 1'b0;
    low_edge = -1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.busy == 1'b0) begin
        done = 1'b1;
        low_edge = cyc;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s actual=busy stuck required=busy low within 60 cycles", nm);
    end
  endtask

  int a, t, e0, low;

  initial begin
    rst_n = 1'b0;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd1);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);

    // INIT: read held at 0 throughout the clear sweep
    obs.delete();
    rst_n = 1'b1; bus.read = 1'b1; bus.addr = 32'h0;
    e0 = cyc + 1;
    wait_ready("init_ready", low);
    chk("init_busy_low_edge", 32'(low - e0), 32'd15);
    @(negedge clk);
    bus.read = 1'b0;
    idle(5);
    chk("init_nrsp", 32'(obs.size()), 32'd1);
    chk_obs("init_rd", 0, e0 + 18, 1'b0, 2'b00, 32'h0);

    // Byte lanes
    obs.delete();
    drive(1'b0, 1'b1, 32'h8, 4'b1111, 32'hAABBCCDD, a);
    drive(1'b0, 1'b1, 32'h8, 4'b0101, 32'h11223344, t);
    drive(1'b1, 1'b0, 32'h8, 4'b0000, 32'h0, t);
    idle(5);
    chk_obs("bl_w1", 0, a + 2, 1'b1, 2'b00, 32'h0);
    chk_obs("bl_w2", 1, a + 3, 1'b1, 2'b00, 32'h0);
    chk_obs("bl_rd", 2, a + 4, 1'b0, 2'b00, 32'hAA22CC44);

    // Back-to-back read-after-write
    obs.delete();
    drive(1'b0, 1'b1, 32'h4, 4'b1111, 32'h5, a);
    drive(1'b1, 1'b0, 32'h4, 4'b0000, 32'h0, t);
    drive(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, t);
    idle(5);
    chk_obs("raw_w", 0, a + 2, 1'b1, 2'b00, 32'h0);
    chk_obs("raw_r1", 1, a + 3, 1'b0, 2'b00, 32'h5);
    chk_obs("raw_r0", 2, a + 4, 1'b0, 2'b00, 32'h0);

    // Decode error just past the top, then check word 0 was not aliased
    obs.delete();
    drive(1'b0, 1'b1, BASE + 32'(4 * MW), 4'b1111, 32'hDEADBEEF, a);
    drive(1'b1, 1'b0, BASE + 32'(4 * MW), 4'b0000, 32'h0, t);
    drive(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, t);
    idle(5);
    chk_obs("dec_w", 0, a + 2, 1'b1, 2'b11, 32'h0);
    chk_obs("dec_r", 1, a + 3, 1'b0, 2'b11, 32'h0);
    chk_obs("dec_w0", 2, a + 4, 1'b0, 2'b00, 32'h0);

    // Last word, empty byte enable, ignored low address bits
    obs.delete();
    drive(1'b0, 1'b1, 32'h3C, 4'b1111, 32'h12345678, a);
    drive(1'b0, 1'b1, 32'h3C, 4'b0000, 32'hFFFFFFFF, t);
    drive(1'b1, 1'b0, 32'h3E, 4'b0000, 32'h0, t);
    idle(5);
    chk_obs("top_w", 0, a + 2, 1'b1, 2'b00, 32'h0);
    chk_obs("be0_w", 1, a + 3, 1'b1, 2'b00, 32'h0);
    chk_obs("top_r", 2, a + 4, 1'b0, 2'b00, 32'h12345678);

    // Simultaneous read+write behaves as a write only
    obs.delete();
    drive(1'b1, 1'b1, 32'hC, 4'b1111, 32'h7, a);
    idle(4);
    drive(1'b1, 1'b0, 32'hC, 4'b0000, 32'h0, t);
    idle(5);
    chk("rw_nrsp", 32'(obs.size()), 32'd2);
    chk_obs("rw_w", 0, a + 2, 1'b1, 2'b00, 32'h0);
    chk_obs("rw_r", 1, t + 2, 1'b0, 2'b00, 32'h7);

    // Reset with two reads in flight
    obs.delete();
    drive(1'b1, 1'b0, 32'h4, 4'b0000, 32'h0, a);
    drive(1'b1, 1'b0, 32'h8, 4'b0000, 32'h0, t);
    @(negedge clk);
    rst_n = 1'b0; bus.read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", 32'(bus.busy), 32'd1);
    e0 = cyc + 1;
    wait_ready("rst_ready", low);
    chk("rst_busy_low_edge", 32'(low - e0), 32'd15);
    chk("rst_nrsp", 32'(obs.size()), 32'd0);
    drive(1'b1, 1'b0, 32'h4, 4'b0000, 32'h0, a);
    drive(1'b1, 1'b0, 32'h8, 4'b0000, 32'h0, t);
    idle(5);
    chk_obs("rst_clr4", 0, a + 2, 1'b0, 2'b00, 32'h0);
    chk_obs("rst_clr8", 1, a + 3, 1'b0, 2'b00, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=still running required=finished by 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
